// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back data cache controller
// Holds the tag/valid/dirty/data arrays and sequences write-back and refill.
module dcache_controller #(
    parameter int ADDR_W   = 8,
    parameter int INDEX_W  = 3,
    parameter int OFFSET_W = 2,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        READ,
    input  logic                        WRITE,
    input  logic [ADDR_W-1:0]           ADDRESS,
    input  logic [7:0]                  WRITEDATA,
    output logic [7:0]                  READDATA,
    output logic                        BUSYWAIT,
    output logic                        MEM_READ,
    output logic                        MEM_WRITE,
    output logic [TAG_W+INDEX_W-1:0]    MEM_ADDRESS,
    output logic [(8<<OFFSET_W)-1:0]    MEM_WRITEDATA,
    input  logic [(8<<OFFSET_W)-1:0]    MEM_READDATA,
    input  logic                        MEM_BUSYWAIT
);
    localparam int SETS  = 1 << INDEX_W;
    localparam int BLK_W = 8 << OFFSET_W;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_MEM_WRITE = 2'd1;
    localparam logic [1:0] S_MEM_READ  = 2'd2;
    localparam logic [1:0] S_UPDATE    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [BLK_W-1:0]  data_q [SETS];

    logic [TAG_W-1:0]    addr_tag;
    logic [INDEX_W-1:0]  idx;
    logic [OFFSET_W-1:0] off;
    logic [BLK_W-1:0]    cur_data;
    logic                request, hit, fill, store;

    assign addr_tag = ADDRESS[ADDR_W-1 -: TAG_W];
    assign idx      = ADDRESS[OFFSET_W +: INDEX_W];
    assign off      = ADDRESS[OFFSET_W-1:0];
    assign cur_data = data_q[idx];

    assign request = READ | WRITE;
    assign hit     = valid_q[idx] & (tag_q[idx] == addr_tag);

    // A simultaneous READ and WRITE is serviced as a store.
    assign fill  = (state_q == S_MEM_READ) & ~MEM_BUSYWAIT;
    assign store = (state_q == S_IDLE) & WRITE & hit;

    assign READDATA      = cur_data[{off, 3'b000} +: 8];
    assign BUSYWAIT      = (state_q != S_IDLE) | (request & ~hit);
    assign MEM_READ      = (state_q == S_MEM_READ);
    assign MEM_WRITE     = (state_q == S_MEM_WRITE);
    assign MEM_WRITEDATA = cur_data;
    assign MEM_ADDRESS   = (state_q == S_MEM_WRITE) ? {tag_q[idx], idx} : {addr_tag, idx};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (request && !hit) begin
                    state_d = (valid_q[idx] && dirty_q[idx]) ? S_MEM_WRITE : S_MEM_READ;
                end
            end
            S_MEM_WRITE: if (!MEM_BUSYWAIT) state_d = S_MEM_READ;
            S_MEM_READ:  if (!MEM_BUSYWAIT) state_d = S_UPDATE;
            S_UPDATE:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Tag and data arrays are never cleared; reset only invalidates and blocks array writes.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (fill) begin
                data_q[idx]  <= MEM_READDATA;
                tag_q[idx]   <= addr_tag;
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (store) begin
                data_q[idx][{off, 3'b000} +: 8] <= WRITEDATA;
                dirty_q[idx] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - directed vector bench for dcache_controller
// Memory responder holds MEM_BUSYWAIT high for mem_lat cycles of each transaction.
module tb_dcache_controller;
    logic        CLK = 1'b0;
    logic        RESET, READ, WRITE;
    logic [7:0]  ADDRESS, WRITEDATA, READDATA;
    logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA, MEM_READDATA;

    int checks = 0;
    int errors = 0;
    int mem_lat = 0;
    int mem_cnt = 0;
    logic [31:0] wb [64];
    logic [63:0] written = '0;

    dcache_controller dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
        .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
        .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_blk(input logic [5:0] a);
        case (a)
            6'h09:   return 32'hDDCCBBAA;
            6'h11:   return 32'h44332211;
            6'h23:   return 32'h0D0C0B0A;
            6'h03:   return 32'h87654321;
            6'h0C:   return 32'hF0E0D0C0;
            default: return {26'h0, a};
        endcase
    endfunction

    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt < mem_lat);
    assign MEM_READDATA = written[MEM_ADDRESS] ? wb[MEM_ADDRESS] : init_blk(MEM_ADDRESS);

    always @(posedge CLK) begin
        if (MEM_WRITE && !MEM_BUSYWAIT) begin
            wb[MEM_ADDRESS]      <= MEM_WRITEDATA;
            written[MEM_ADDRESS] <= 1'b1;
        end
        mem_cnt <= ((MEM_READ || MEM_WRITE) && MEM_BUSYWAIT) ? mem_cnt + 1 : 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // stall counts busy cycles after the request edge (state residency), not the IDLE detect cycle.
    task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                          input int lat, output int stall, output logic [7:0] rdat,
                          output logic saw_mr, output logic [5:0] mr_a,
                          output logic saw_mw, output logic [5:0] mw_a, output logic [31:0] mw_d,
                          output logic both, output logic tmo);
        int n;
        mem_lat = lat;
        READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
        n = 0; saw_mr = 0; saw_mw = 0; both = 0; tmo = 0;
        mr_a = '0; mw_a = '0; mw_d = '0;
        forever begin
            @(negedge CLK);
            if (MEM_READ && MEM_WRITE) both = 1;
            if (MEM_READ && !saw_mr) begin saw_mr = 1; mr_a = MEM_ADDRESS; end
            if (MEM_WRITE && !saw_mw) begin saw_mw = 1; mw_a = MEM_ADDRESS; mw_d = MEM_WRITEDATA; end
            if (!BUSYWAIT) break;
            n++;
            if (n > 200) begin tmo = 1; break; end
        end
        stall = (n == 0) ? 0 : n - 1;
        rdat = READDATA;
        @(posedge CLK);
        #1;
        READ = 0; WRITE = 0;
    endtask

    typedef struct {
        logic        rd, wr;
        logic [7:0]  addr, wdata;
        int          lat, stall;
        logic        chk_rd;
        logic [7:0]  rdata;
        logic        mr;
        logic [5:0]  mr_a;
        logic        mw;
        logic [5:0]  mw_a;
        logic [31:0] mw_d;
    } vec_t;

    vec_t vt[16];

    task automatic run_vec(input int i, input vec_t v);
        int st;
        logic [7:0] rdat;
        logic smr, smw, both, tmo;
        logic [5:0] mra, mwa;
        logic [31:0] mwd;
        access(v.rd, v.wr, v.addr, v.wdata, v.lat, st, rdat, smr, mra, smw, mwa, mwd, both, tmo);
        chk($sformatf("v%0d timeout", i), {31'b0, tmo}, 32'd0);
        chk($sformatf("v%0d stall", i), st, v.stall);
        chk($sformatf("v%0d mem_read_seen", i), {31'b0, smr}, {31'b0, v.mr});
        chk($sformatf("v%0d mem_write_seen", i), {31'b0, smw}, {31'b0, v.mw});
        chk($sformatf("v%0d rd_wr_exclusive", i), {31'b0, both}, 32'd0);
        if (v.chk_rd) chk($sformatf("v%0d readdata", i), {24'b0, rdat}, {24'b0, v.rdata});
        if (v.mr) chk($sformatf("v%0d mr_addr", i), {26'b0, mra}, {26'b0, v.mr_a});
        if (v.mw) begin
            chk($sformatf("v%0d mw_addr", i), {26'b0, mwa}, {26'b0, v.mw_a});
            chk($sformatf("v%0d mw_data", i), mwd, v.mw_d);
        end
    endtask

    initial begin
        vt[0]  = '{1'b1, 1'b0, 8'h25, 8'h00, 5, 7,  1'b1, 8'hBB, 1'b1, 6'h09, 1'b0, 6'h00, 32'h0};
        vt[1]  = '{1'b1, 1'b0, 8'h24, 8'h00, 0, 0,  1'b1, 8'hAA, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0};
        vt[2]  = '{1'b1, 1'b0, 8'h26, 8'h00, 0, 0,  1'b1, 8'hCC, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0};
        vt[3]  = '{1'b1, 1'b0, 8'h27, 8'h00, 0, 0,  1'b1, 8'hDD, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0};
        vt[4]  = '{1'b0, 1'b1, 8'h26, 8'h5A, 0, 0,  1'b0, 8'h00, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0};
        vt[5]  = '{1'b1, 1'b0, 8'h26, 8'h00, 0, 0,  1'b1, 8'h5A, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0};
        vt[6]  = '{1'b1, 1'b0, 8'h25, 8'h00, 0, 0,  1'b1, 8'hBB, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0};
        vt[7]  = '{1'b1, 1'b0, 8'h27, 8'h00, 0, 0,  1'b1, 8'hDD, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0};
        vt[8]  = '{1'b1, 1'b0, 8'h45, 8'h00, 5, 13, 1'b1, 8'h22, 1'b1, 6'h11, 1'b1, 6'h09, 32'hDD5ABBAA};
        vt[9]  = '{1'b0, 1'b1, 8'h8C, 8'h77, 3, 5,  1'b0, 8'h00, 1'b1, 6'h23, 1'b0, 6'h00, 32'h0};
        vt[10] = '{1'b1, 1'b0, 8'h8C, 8'h00, 0, 0,  1'b1, 8'h77, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0};
        vt[11] = '{1'b1, 1'b0, 8'h0C, 8'h00, 2, 7,  1'b1, 8'h21, 1'b1, 6'h03, 1'b1, 6'h23, 32'h0D0C0B77};
        vt[12] = '{1'b1, 1'b0, 8'h26, 8'h00, 0, 2,  1'b1, 8'h5A, 1'b1, 6'h09, 1'b0, 6'h00, 32'h0};
        vt[13] = '{1'b1, 1'b1, 8'h25, 8'h99, 0, 0,  1'b0, 8'h00, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0};
        vt[14] = '{1'b1, 1'b0, 8'h25, 8'h00, 0, 0,  1'b1, 8'h99, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0};
        vt[15] = '{1'b1, 1'b0, 8'h24, 8'h00, 0, 0,  1'b1, 8'hAA, 1'b0, 6'h00, 1'b0, 6'h00, 32'h0};

        RESET = 0; READ = 0; WRITE = 0; ADDRESS = 0; WRITEDATA = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset busywait", {31'b0, BUSYWAIT}, 32'd0);
        chk("reset mem_read", {31'b0, MEM_READ}, 32'd0);
        chk("reset mem_write", {31'b0, MEM_WRITE}, 32'd0);
        RESET = 1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 16; i++) run_vec(i, vt[i]);

        // Reset during a refill: transaction dropped, valid and dirty bits cleared.
        mem_lat = 10;
        READ = 1; ADDRESS = 8'h31;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("midmiss mem_read before reset", {31'b0, MEM_READ}, 32'd1);
        RESET = 0;
        @(negedge CLK);
        chk("midmiss mem_read after reset", {31'b0, MEM_READ}, 32'd0);
        chk("midmiss mem_write after reset", {31'b0, MEM_WRITE}, 32'd0);
        READ = 0; RESET = 1;
        @(negedge CLK);
        chk("midmiss idle busywait", {31'b0, BUSYWAIT}, 32'd0);
        @(posedge CLK);
        #1;
        run_vec(16, '{1'b1, 1'b0, 8'h24, 8'h00, 0, 2, 1'b1, 8'hAA, 1'b1, 6'h09, 1'b0, 6'h00, 32'h0});
        run_vec(17, '{1'b1, 1'b0, 8'h31, 8'h00, 0, 2, 1'b1, 8'hD0, 1'b1, 6'h0C, 1'b0, 6'h00, 32'h0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back data cache controller between the CPU load/store path and the 32-bit-block main data memory.
- Services byte reads and writes from the CPU. Stalls the CPU via BUSYWAIT on a miss.
- Sequences the memory write-back and fetch through a four-state FSM, and holds the tag, valid, dirty and data arrays.

Parameters:
- ADDR_W, 8, CPU byte address width.
- INDEX_W, 3, set index width (8 sets).
- OFFSET_W, 2, byte offset width (4-byte blocks).
- TAG_W, ADDR_W-INDEX_W-OFFSET_W = 3, tag width.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-low reset.
- READ  in  1  CPU load request.
- WRITE  in  1  CPU store request.
- ADDRESS  in  8  CPU byte address.
- WRITEDATA  in  8  CPU store byte.
- READDATA  out  8  load byte.
- BUSYWAIT  out  1  CPU stall.
- MEM_READ  out  1  memory block read request.
- MEM_WRITE  out  1  memory block write request.
- MEM_ADDRESS  out  6  block address {tag,index}.
- MEM_WRITEDATA  out  32  write-back block; byte0 at [7:0].
- MEM_READDATA  in  32  fetched block; byte0 at [7:0].
- MEM_BUSYWAIT  in  1  memory busy.

Behaviour:
- Address split: tag=ADDRESS[7:5], index=ADDRESS[4:2], offset=ADDRESS[1:0].
- Per set: valid bit, dirty bit, 3-bit tag, 32-bit data.
- hit = valid[index] & (tag[index]==ADDRESS tag).
- Request = READ|WRITE. READ and WRITE both high is treated as WRITE.
- CPU holds ADDRESS, WRITEDATA, READ and WRITE stable while BUSYWAIT=1.
- BUSYWAIT = (state!=IDLE) | (request & ~hit). It is combinational.
- READDATA: combinational byte select of data[index] at offset. Valid whenever request & hit in IDLE; don't-care otherwise.
- Read hit: BUSYWAIT=0, zero-cycle latency, no state change.
- Write hit in IDLE: at the rising edge, data[index] byte[offset]←WRITEDATA and dirty[index]←1. Other bytes are unchanged.
- States: IDLE, MEM_WRITE, MEM_READ, UPDATE.
- IDLE:
  - request & ~hit & ~dirty[index] → MEM_READ.
  - request & ~hit & valid & dirty → MEM_WRITE.
  - Otherwise stay in IDLE.
- MEM_WRITE:
  - Outputs: MEM_WRITE=1, MEM_ADDRESS={tag[index],index}, MEM_WRITEDATA=data[index].
  - At an edge with MEM_BUSYWAIT=0 → MEM_READ. Otherwise stay.
- MEM_READ:
  - Outputs: MEM_READ=1, MEM_ADDRESS={ADDRESS tag,index}.
  - At an edge with MEM_BUSYWAIT=0: data[index]←MEM_READDATA, tag[index]←ADDRESS tag, valid←1, dirty←0, then → UPDATE. Otherwise stay.
- UPDATE: one bubble cycle with BUSYWAIT=1, then → IDLE. The request then hits; a pending store completes as a write hit.
- Every state lasts at least one cycle. MEM_BUSYWAIT sampled low on the entry edge does not skip a state.
- MEM_READ and MEM_WRITE are never both 1. Outside their states both are 0, and MEM_ADDRESS/MEM_WRITEDATA are don't-care.
- Latency, clean miss with memory busy for M cycles: BUSYWAIT high for M+2 cycles (MEM_READ M+1, UPDATE 1).
- Latency, dirty miss with memory busy for M cycles per transaction: 2M+3 cycles.
- Request deasserted mid-miss is illegal. The controller completes the fill regardless.
- Reset, at a rising edge with RESET=0:
  - state←IDLE; all valid←0; all dirty←0. Tag and data arrays are not cleared.
  - Takes effect mid-miss too: the memory transaction is abandoned and MEM_READ/MEM_WRITE fall in the cycle after the edge.
  - After reset with no request: BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0.
  - Reset has priority over every transition and every array write in the same edge.

Test Plan:
- Reset, then READ addr 0x25 (index1, tag1); memory returns 0xDDCCBBAA after M=5 busy cycles → MEM_READ=1 with MEM_ADDRESS=0x09; BUSYWAIT high 7 cycles; READDATA=0xBB.
- Read hit: READ 0x24, 0x26, 0x27 consecutively → BUSYWAIT=0 each cycle; READDATA 0xAA, 0xCC, 0xDD; no memory requests.
- Write hit: WRITE 0x26 with data 0x5A, then READ 0x26 → 0x5A; neighbouring bytes unchanged.
- Dirty miss: READ 0x45 (index1, tag2) after the store above → MEM_WRITE, MEM_ADDRESS=0x09, MEM_WRITEDATA=0xDD5ABBAA; then MEM_READ with MEM_ADDRESS=0x11; with M=5, BUSYWAIT high 13 cycles.
- Write miss to a clean set: WRITE 0x8C with data 0x77 → fetch block 0x23, then store; dirty[3]=1 and READ 0x8C → 0x77.
- Reset asserted mid-MEM_READ → next cycle MEM_READ=0, state IDLE; re-READ of the same address misses again (valid cleared).
